// File: rtl/stickman_pkg.sv
// Shared types for the coin lane manager: screen geometry, per-channel coin
// record and the update FSM state encoding.
package stickman_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // One coin channel: x is 11 bits so a freshly spawned coin at SCREEN_W and
  // x + COIN_SIZE both fit without wrapping.
  typedef struct packed {
    logic        active;
    logic [10:0] x;
    logic [9:0]  y;
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    UPD,
    SPAWN
  } coin_fsm_e;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), advanced one step per cycle with en.
// Ports:
//   Clk      system clock
//   Reset_n  asynchronous active-low reset, loads SEED
//   en       advance enable
//   q        current LFSR state
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/coin_lane_manager.sv
// N-channel coin engine: once per frame it scrolls every active coin left,
// collects coins overlapping the stickman hitbox, and periodically spawns a
// new coin at the right screen edge. Also renders coins for the pixel pipe.
// Optional feature macro: COIN_MAGNET_EN (coins near the stickman drift
// vertically toward its centre by 1 px per frame).
// Ports:
//   Clk, Reset_n          system clock, asynchronous active-low reset
//   frame_clk             VGA_VS, asynchronous; rising edge = one frame tick
//   playing               1 = advance motion/spawn on ticks
//   restart               synchronous clear of coins, count and spawn counter
//   scroll_speed          px per frame coins move left
//   StickmanTop/Bottom    hitbox vertical extent (inclusive)
//   DrawX, DrawY          current pixel
//   is_coin               pixel inside an active coin (registered)
//   CoinStatus            per-channel active bits
//   coin_count            saturating collected-coin count
//   collect_pulse         one-cycle strobe per collected coin
module coin_lane_manager
  import stickman_pkg::*;
#(
  parameter int unsigned N_COIN    = 3,
  parameter int unsigned COIN_SIZE = 16,
  parameter int unsigned SPAWN_GAP = 45,
  parameter int unsigned Y_MIN     = 200,
  parameter int unsigned Y_BITS    = 7,
  parameter int unsigned STICK_X   = 120,
  parameter int unsigned STICK_W   = 24,
  parameter int unsigned MAGNET_DX = 96
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic              playing,
  input  logic              restart,
  input  logic [3:0]        scroll_speed,
  input  logic [9:0]        StickmanTop,
  input  logic [9:0]        StickmanBottom,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              is_coin,
  output logic [N_COIN-1:0] CoinStatus,
  output logic [15:0]       coin_count,
  output logic              collect_pulse
);

  localparam int unsigned IdxW   = (N_COIN > 1) ? $clog2(N_COIN) : 1;
  localparam logic [10:0] CoinSz = 11'(COIN_SIZE);
  localparam logic [10:0] StickL = 11'(STICK_X);
  localparam logic [10:0] StickR = 11'(STICK_X + STICK_W);
  localparam logic [10:0] SpawnX = 11'(SCREEN_W);
  localparam logic [9:0]  YBase  = 10'(Y_MIN);
  localparam logic [15:0] GapEnd = 16'(SPAWN_GAP - 1);

  if (N_COIN < 1 || N_COIN > 8) begin : g_bad_n_coin
    $error("N_COIN must be 1..8");
  end
  if (SPAWN_GAP < 1) begin : g_bad_gap
    $error("SPAWN_GAP must be >= 1");
  end
  if (MAGNET_DX > SCREEN_W) begin : g_bad_magnet
    $error("MAGNET_DX wider than the screen");
  end

  coin_fsm_e        state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  coin_t            coins_q [N_COIN];
  coin_t            coins_d [N_COIN];
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             is_coin_q, is_coin_d;
  logic [2:0]       fs_q;
  logic             tick;
  logic [15:0]      lfsr_q;
  logic             free_found;
  logic [IdxW-1:0]  free_idx;
  coin_t            cur, nxt;
  logic [10:0]      nx;
  logic [9:0]       ny;

  // fs_q[0] may go metastable; fs_q[1] is the synchronised level.
  assign tick = fs_q[1] & ~fs_q[2];

  lfsr16 #(
    .SEED (16'hACE1)
  ) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .en      ((state_q == SPAWN) && !restart),
    .q       (lfsr_q)
  );

  // Lowest-index inactive channel for the spawn step.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_COIN - 1; i >= 0; i--) begin
      if (!coins_q[i].active) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    coins_d   = coins_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    pulse_d   = 1'b0;
    cur       = coins_q[idx_q];
    nxt       = cur;
    nx        = cur.x;
    ny        = cur.y;

    unique case (state_q)
      IDLE: begin
        if (tick && playing) begin
          state_d = UPD;
          idx_d   = '0;
        end
      end

      UPD: begin
        if (cur.active) begin
          if (cur.x < 11'(scroll_speed)) begin
            nxt.active = 1'b0;
          end else begin
            nx = cur.x - 11'(scroll_speed);
`ifdef COIN_MAGNET_EN
            if (nx >= StickL && (nx - StickL) < 11'(MAGNET_DX)) begin
              if ({1'b0, cur.y} < (({1'b0, StickmanTop} + {1'b0, StickmanBottom}) >> 1)) begin
                ny = cur.y + 10'd1;
              end else if ({1'b0, cur.y} >
                           (({1'b0, StickmanTop} + {1'b0, StickmanBottom}) >> 1)) begin
                ny = cur.y - 10'd1;
              end
            end
`endif
            nxt.x = nx;
            nxt.y = ny;
            // AABB overlap of the moved coin with the stickman hitbox.
            if (nx < StickR && (nx + CoinSz) > StickL &&
                ny <= StickmanBottom && ({1'b0, ny} + CoinSz) > {1'b0, StickmanTop}) begin
              nxt.active = 1'b0;
              pulse_d    = 1'b1;
              if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
              end
            end
          end
          coins_d[idx_q] = nxt;
        end
        if (idx_q == IdxW'(N_COIN - 1)) begin
          state_d = SPAWN;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end

      SPAWN: begin
        state_d = IDLE;
        if (cnt_q == GapEnd) begin
          // With every lane busy the counter parks here so the next free
          // lane is filled on the very next tick.
          if (free_found) begin
            coins_d[free_idx].active = 1'b1;
            coins_d[free_idx].x      = SpawnX;
            coins_d[free_idx].y      = YBase + 10'(lfsr_q[Y_BITS-1:0]);
            cnt_d                    = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      count_d = '0;
      pulse_d = 1'b0;
      for (int i = 0; i < N_COIN; i++) begin
        coins_d[i] = '0;
      end
    end
  end

  always_comb begin
    is_coin_d = 1'b0;
    for (int i = 0; i < N_COIN; i++) begin
      if (coins_q[i].active &&
          {1'b0, DrawX} >= coins_q[i].x && {1'b0, DrawX} < (coins_q[i].x + CoinSz) &&
          {1'b0, DrawY} >= {1'b0, coins_q[i].y} &&
          {1'b0, DrawY} < ({1'b0, coins_q[i].y} + CoinSz)) begin
        is_coin_d = 1'b1;
      end
    end
    if (restart) begin
      is_coin_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      is_coin_q <= 1'b0;
      fs_q      <= '0;
      for (int i = 0; i < N_COIN; i++) begin
        coins_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      is_coin_q <= is_coin_d;
      fs_q      <= {fs_q[1:0], frame_clk};
      for (int i = 0; i < N_COIN; i++) begin
        coins_q[i] <= coins_d[i];
      end
    end
  end

  always_comb begin
    CoinStatus = '0;
    for (int i = 0; i < N_COIN; i++) begin
      CoinStatus[i] = coins_q[i].active;
    end
  end

  assign is_coin       = is_coin_q;
  assign coin_count    = count_q;
  assign collect_pulse = pulse_q;

  // A frame tick arriving mid-update is dropped by design; flag it.
  assert property (@(posedge Clk) disable iff (!Reset_n) !(tick && state_q != IDLE))
    else $warning("coin_lane_manager: frame tick dropped while busy");

  assert property (@(posedge Clk) disable iff (!Reset_n) lfsr_q != 16'h0000)
    else $error("coin_lane_manager: LFSR reached zero");

endmodule
